// File: rtl/demux1x2_4b_buf_pkg.sv
// Shared constants for the 1-to-2 buffered demultiplexer: default widths and
// the channel index encoding used by the select input.
package demux1x2_4b_buf_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

endpackage : demux1x2_4b_buf_pkg

// File: rtl/demux1x2_4b_buf_slot.sv
// demux_slot: one-entry output buffer (data register + valid flag) with an
// optional saturating delivery counter enabled by DEMUX_DELIVERY_CNT_EN.
module demux_slot
  import demux1x2_4b_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // NOTE: defaults first so every path assigns the signal and no latch is inferred.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    // A load in the same cycle as a drain wins, keeping the slot full.
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout      = data_q;
  assign out_valid = valid_q;

`ifdef DEMUX_DELIVERY_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule : demux_slot

// File: rtl/demux1x2_4b_buf.sv
// 1-to-2 demultiplexer with a one-entry buffer per output channel. Optional
// per-channel delivery counters are enabled by DEMUX_DELIVERY_CNT_EN.
module demux1x2_4b_buf
  import demux1x2_4b_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic             out_valid0,
  output logic             out_valid1,
  input  logic             out_ready0,
  input  logic             out_ready1,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  ch_e  sel;
  logic load0, load1;

  assign sel = ch_e'(s);

  // Ready looks only at the selected channel, so a stalled channel never
  // blocks traffic to the other one.
  always_comb begin
    in_ready = 1'b1;
    load0    = 1'b0;
    load1    = 1'b0;
    if (sel == CH1) begin
      in_ready = !out_valid1 || out_ready1;
      load1    = in_valid && in_ready;
    end else begin
      in_ready = !out_valid0 || out_ready0;
      load0    = in_valid && in_ready;
    end
  end

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .din       (din),
    .out_ready (out_ready0),
    .dout      (dout0),
    .out_valid (out_valid0),
    .cnt       (cnt0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .din       (din),
    .out_ready (out_ready1),
    .dout      (dout1),
    .out_valid (out_valid1),
    .cnt       (cnt1)
  );

endmodule : demux1x2_4b_buf

// File: tb/tb_demux1x2_4b_buf.sv
// Directed self-checking bench for demux1x2_4b_buf; counter expectations
// follow DEMUX_DELIVERY_CNT_EN.
module tb_demux1x2_4b_buf;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             s;
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dout0, dout1;
  logic             out_valid0, out_valid1;
  logic             out_ready0, out_ready1;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux1x2_4b_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s),
    .din        (din),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout0      (dout0),
    .dout1      (dout1),
    .out_valid0 (out_valid0),
    .out_valid1 (out_valid1),
    .out_ready0 (out_ready0),
    .out_ready1 (out_ready1),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    rst = 1'b1; s = 1'b0; din = '0; in_valid = 1'b0;
    out_ready0 = 1'b0; out_ready1 = 1'b0;
    #3;
    check("rst_valid0", 32'(out_valid0), 32'd0);
    check("rst_valid1", 32'(out_valid1), 32'd0);
    check("rst_dout0",  32'(dout0), 32'd0);
    check("rst_dout1",  32'(dout1), 32'd0);
    check("rst_ready",  32'(in_ready), 32'd1);
    check("rst_cnt0",   32'(cnt0), 32'd0);
    check("rst_cnt1",   32'(cnt1), 32'd0);
    tick();
    rst = 1'b0;

    // Steering to channel 1.
    s = 1'b1; din = 4'hA; in_valid = 1'b1; out_ready0 = 1'b1; out_ready1 = 1'b1;
    #1 check("steer_ready", 32'(in_ready), 32'd1);
    tick();
    check("steer_valid1", 32'(out_valid1), 32'd1);
    check("steer_dout1",  32'(dout1), 32'hA);
    check("steer_valid0", 32'(out_valid0), 32'd0);
    in_valid = 1'b0;
    tick();
    check("steer_drain1", 32'(out_valid1), 32'd0);

    // Backpressure on channel 0.
    out_ready0 = 1'b0; s = 1'b0; din = 4'h3; in_valid = 1'b1;
    tick();
    check("bp_load_dout0", 32'(dout0), 32'h3);
    din = 4'h7;
    #1 check("bp_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_dout0",  32'(dout0), 32'h3);
      check("bp_hold_valid0", 32'(out_valid0), 32'd1);
    end
    out_ready0 = 1'b1;
    #1 check("bp_ready_high", 32'(in_ready), 32'd1);
    tick();
    check("bp_new_dout0",  32'(dout0), 32'h7);
    check("bp_new_valid0", 32'(out_valid0), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drain0", 32'(out_valid0), 32'd0);

    // Asynchronous reset mid-stream discards the buffered word.
    out_ready0 = 1'b0; s = 1'b0; din = 4'h5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_loaded0", 32'(out_valid0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid0", 32'(out_valid0), 32'd0);
    check("mid_rst_dout0",  32'(dout0), 32'd0);
    check("mid_rst_ready",  32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    din = 4'h9; in_valid = 1'b1;
    tick();
    check("post_rst_valid0", 32'(out_valid0), 32'd1);
    check("post_rst_dout0",  32'(dout0), 32'h9);
    in_valid = 1'b0; out_ready0 = 1'b1;
    tick();
    check("post_rst_drain0", 32'(out_valid0), 32'd0);

    // Independence: channel 0 stalled full while channel 1 streams.
    out_ready0 = 1'b0; s = 1'b0; din = 4'hE; in_valid = 1'b1;
    tick();
    s = 1'b1; out_ready1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din = WIDTH'(i);
      #1 check("ind_ready", 32'(in_ready), 32'd1);
      tick();
      check("ind_dout1",  32'(dout1), 32'(i));
      check("ind_valid1", 32'(out_valid1), 32'd1);
      check("ind_dout0",  32'(dout0), 32'hE);
    end
    in_valid = 1'b0;
    tick();
    check("ind_drain1", 32'(out_valid1), 32'd0);
    check("ind_hold0",  32'(out_valid0), 32'd1);
    out_ready0 = 1'b1;
    tick();
    check("ind_drain0", 32'(out_valid0), 32'd0);

    // Full throughput on channel 0.
    s = 1'b0; out_ready0 = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = WIDTH'(i);
      #1 check("tp_ready", 32'(in_ready), 32'd1);
      tick();
      check("tp_valid0", 32'(out_valid0), 32'd1);
      check("tp_dout0",  32'(dout0), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("tp_drain0", 32'(out_valid0), 32'd0);

    // Delivery counters: 3 drains, then 300 drains on channel 1.
    do_reset();
    s = 1'b1; out_ready1 = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    tick();
`ifdef DEMUX_DELIVERY_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    check("cnt1_small", 32'(cnt1), 32'(exp_cnt));
    check("cnt0_small", 32'(cnt0), 32'd0);
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din = WIDTH'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
`ifdef DEMUX_DELIVERY_CNT_EN
    exp_cnt = 255;
`else
    exp_cnt = 0;
`endif
    check("cnt1_sat", 32'(cnt1), 32'(exp_cnt));
    check("cnt0_sat", 32'(cnt0), 32'd0);
    check("cnt_valid1", 32'(out_valid1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_demux1x2_4b_buf

// File: doc/demux1x2_4b_buf.md
DEMUX1X2_4B_BUF -- requirements
Module: demux1x2_4b_buf

Interface
REQ-001 Parameter WIDTH, default 4, data width of input and both output channels.
REQ-002 Parameter CNT_W, default 8, width of per-output delivery counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s  input  1  destination select: 0 -> channel 0, 1 -> channel 1; sampled with in_valid.
REQ-006 din  input  WIDTH  input data word.
REQ-007 in_valid  input  1  producer offers din/s this cycle.
REQ-008 in_ready  output  1  block accepts din this cycle.
REQ-009 dout0 / dout1  output  WIDTH  registered data of channel 0 / 1.
REQ-010 out_valid0 / out_valid1  output  1  channel 0 / 1 holds a word.
REQ-011 out_ready0 / out_ready1  input  1  consumer of channel 0 / 1 takes the word.
REQ-012 cnt0 / cnt1  output  CNT_W  words delivered on channel 0 / 1 (see Configuration).

Function
REQ-013 Each channel k SHALL hold exactly one entry: register doutk plus flag out_validk.
REQ-014 in_ready SHALL be combinational: !out_valid[s] || out_ready[s]; it SHALL NOT depend on the unselected channel.
REQ-015 Accept = in_valid && in_ready; on accept, dout[s] <= din and out_valid[s] <= 1 at the next edge (latency 1 cycle).
REQ-016 Drain on channel k = out_validk && out_readyk; with no same-cycle accept to k, out_validk SHALL clear at the next edge.
REQ-017 Simultaneous drain and accept on the same channel SHALL keep out_validk = 1 and load the new word (full throughput, 1 word/cycle/channel).
REQ-018 The unselected channel's state SHALL be unchanged by an accept; both channels SHALL drain independently in the same cycle.
REQ-019 While out_validk = 1 and out_readyk = 0, doutk SHALL be held stable.
REQ-020 in_valid = 0 SHALL cause no state change except drains; s and din are don't-care.
REQ-021 No word SHALL be lost or duplicated: every accept produces exactly one drain on the selected channel.

Reset
REQ-022 While rst = 1: out_valid0/1 = 0, dout0/1 = 0, cnt0/1 = 0, in_ready = 1 (both channels empty), regardless of clk.
REQ-023 rst asserted mid-operation SHALL discard buffered words; first accept after rst deasserts SHALL behave as from empty.

Configuration
REQ-024 Macro DEMUX_DELIVERY_CNT_EN: when defined, cntk SHALL increment by 1 on each drain of channel k and saturate at 2^CNT_W-1 (no wrap).
REQ-025 When DEMUX_DELIVERY_CNT_EN is undefined, cnt0/cnt1 ports SHALL remain present and be driven constant 0; no counter registers synthesised.

Structure
REQ-026 Shared package SHALL hold WIDTH and CNT_W default constants and the channel index encoding (CH0 = 0, CH1 = 1).
REQ-027 One sub-module demux_slot (one-entry register + valid flag + optional counter) SHALL be instantiated twice; top contains only select/ready steering.

Verification
REQ-028 Reset: rst=1 mid-stream with out_valid0=1 -> out_valid0=0, dout0=4'h0, in_ready=1 immediately (asynchronous).
REQ-029 Steering: s=1, din=4'hA, in_valid=1, both ready=1 -> next cycle out_valid1=1, dout1=4'hA, out_valid0=0.
REQ-030 Backpressure: channel 0 full (dout0=4'h3), out_ready0=0, s=0, din=4'h7 -> in_ready=0, dout0 stays 4'h3 for 5 cycles; raise out_ready0 -> 4'h7 loaded next edge.
REQ-031 Independence: channel 0 stalled full, s=1 stream 4'h1..4'h4 with out_ready1=1 -> in_ready=1 each cycle, channel 1 delivers 1,2,3,4 in order.
REQ-032 Throughput: s=0, in_valid=1, out_ready0=1 for 16 cycles, din 0..F -> 16 drains in order, in_ready never 0.
REQ-033 Counter (DEMUX_DELIVERY_CNT_EN defined, CNT_W=8): 300 drains on channel 1 -> cnt1=255, cnt0=0; macro undefined -> cnt0=cnt1=0 throughout.
